// File: rtl/stage_pkg.sv
// Shared stage definitions: opcodes, fetch FSM
// encoding and instruction-length decode.
package stage_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    F_OP  = 2'd1,
    F_DAT = 2'd2,
    FULL  = 2'd3
  } state_e;

  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_OR     = 5'd2;
  localparam logic [4:0] OP_AND    = 5'd3;
  localparam logic [4:0] OP_MULDIV = 5'd4;
  localparam logic [4:0] OP_SHFT   = 5'd5;
  localparam logic [4:0] OP_BRA    = 5'd6;
  localparam logic [4:0] OP_LOAD   = 5'd7;
  localparam logic [4:0] OP_STOR   = 5'd8;
  localparam logic [4:0] OP_LDA    = 5'd9;
  localparam logic [4:0] OP_STA    = 5'd10;
  localparam logic [4:0] OP_LDB    = 5'd11;
  localparam logic [4:0] OP_STB    = 5'd12;
  localparam logic [4:0] OP_LMSK   = 5'd13;
  localparam logic [4:0] OP_COMP   = 5'd16;
  localparam logic [4:0] OP_RTS    = 5'd17;
  localparam logic [4:0] OP_RTI    = 5'd18;
  localparam logic [4:0] OP_INPUT  = 5'd19;
  localparam logic [4:0] OP_OUTPUT = 5'd20;
  localparam logic [4:0] OP_NOP    = 5'd21;

  // Opcodes 14, 15 and 22..31 are undefined
  // and fetched as one-byte instructions.
  function automatic logic is_two_byte(
    input logic [7:0] ir
  );
    logic r;
    r = 1'b0;
    case (ir[7:3])
      OP_ADD, OP_SUB, OP_OR, OP_AND,
      OP_MULDIV, OP_SHFT, OP_BRA,
      OP_LOAD, OP_STOR, OP_LDA, OP_STA,
      OP_LDB, OP_STB, OP_LMSK: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/stage0_if.sv
// Fetch-stage bus: memory read port, stage-1
// handshake and branch redirect.
interface stage0_if;
  logic [7:0] mem_rdata;
  logic       cache_hit;
  logic       stg1_state;
  logic       br_taken;
  logic [7:0] br_target;
  logic       mem_rd;
  logic [7:0] mem_addr;
  logic [7:0] instr;
  logic [7:0] ir_data;
  logic       stg0_state;
  logic [7:0] pc;

  modport master (
    input  mem_rdata, cache_hit,
    input  stg1_state, br_taken,
    input  br_target,
    output mem_rd, mem_addr, instr,
    output ir_data, stg0_state, pc
  );

  modport slave (
    output mem_rdata, cache_hit,
    output stg1_state, br_taken,
    output br_target,
    input  mem_rd, mem_addr, instr,
    input  ir_data, stg0_state, pc
  );
endinterface

// File: rtl/fetch_buf.sv
// One-instruction prefetch buffer holding the
// opcode byte and operand byte with a valid flag.
module fetch_buf
  import stage_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic       flush_i,
  input  logic       ld_op_i,
  input  logic       ld_dat_i,
  input  logic       pop_i,
  input  logic [7:0] rdata_i,
  output logic [7:0] op_o,
  output logic [7:0] dat_o,
  output logic       full_o
);

  logic [7:0] op_q;
  logic [7:0] dat_q;
  logic       vld_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      op_q  <= 8'h00;
      dat_q <= 8'h00;
      vld_q <= 1'b0;
    end else if (flush_i) begin
      op_q  <= 8'h00;
      dat_q <= 8'h00;
      vld_q <= 1'b0;
    end else begin
      if (pop_i)
        vld_q <= 1'b0;
      if (ld_op_i) begin
        op_q <= rdata_i;
        // one-byte ops carry a zero operand
        if (!is_two_byte(rdata_i)) begin
          dat_q <= 8'h00;
          vld_q <= 1'b1;
        end
      end
      if (ld_dat_i) begin
        dat_q <= rdata_i;
        vld_q <= 1'b1;
      end
    end
  end

  assign op_o   = op_q;
  assign dat_o  = dat_q;
  assign full_o = vld_q;

endmodule

// File: rtl/stage0.sv
// Instruction fetch stage: fetches one- or
// two-byte instructions and offers them to stage 1.
module stage0
  import stage_pkg::*;
(
  input  logic     clk,
  input  logic     clr,
  stage0_if.master bus
);

  state_e     state_q;
  logic [7:0] pc_q;
  logic [7:0] instr_q;
  logic [7:0] ir_q;
  logic       stg0_q;

  logic       br;
  logic       ld_op;
  logic       ld_dat;
  logic       xfer;
  logic       handoff;
  logic [7:0] buf_op;
  logic [7:0] buf_dat;
  logic       buf_full;

  assign br = bus.br_taken;

  assign ld_op = (state_q == F_OP)
    && bus.cache_hit && !br;

  assign ld_dat = (state_q == F_DAT)
    && bus.cache_hit && !br;

  // Transfer waits for the prior handoff.
  assign xfer = (state_q == FULL)
    && buf_full && !stg0_q
    && bus.stg1_state && !br;

  assign handoff = stg0_q && bus.stg1_state;

  fetch_buf u_buf (
    .clk      (clk),
    .clr      (clr),
    .flush_i  (br),
    .ld_op_i  (ld_op),
    .ld_dat_i (ld_dat),
    .pop_i    (xfer),
    .rdata_i  (bus.mem_rdata),
    .op_o     (buf_op),
    .dat_o    (buf_dat),
    .full_o   (buf_full)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      pc_q    <= 8'h00;
      instr_q <= 8'h00;
      ir_q    <= 8'h00;
      stg0_q  <= 1'b0;
    end else begin
      if (handoff)
        stg0_q <= 1'b0;
      if (br) begin
        state_q <= F_OP;
        pc_q    <= bus.br_target;
      end else begin
        unique case (state_q)
          IDLE: state_q <= F_OP;
          F_OP: if (bus.cache_hit) begin
            pc_q <= pc_q + 8'd1;
            state_q <=
              is_two_byte(bus.mem_rdata)
              ? F_DAT : FULL;
          end
          F_DAT: if (bus.cache_hit) begin
            pc_q    <= pc_q + 8'd1;
            state_q <= FULL;
          end
          FULL: if (xfer) begin
            instr_q <= buf_op;
            ir_q    <= buf_dat;
            stg0_q  <= 1'b1;
            state_q <= F_OP;
          end
        endcase
      end
    end
  end

  assign bus.mem_rd = (state_q == F_OP)
    || (state_q == F_DAT);
  assign bus.mem_addr   = pc_q;
  assign bus.pc         = pc_q;
  assign bus.instr      = instr_q;
  assign bus.ir_data    = ir_q;
  assign bus.stg0_state = stg0_q;

endmodule

// File: tb/tb_stage0.sv
// Directed bench for stage0: vector table of
// single instructions plus multi-cycle sequences.
module tb_stage0;
  logic       clk;
  logic       clr;
  logic       hit;
  logic       stg1;
  logic       br;
  logic [7:0] tgt;
  logic [7:0] mem [256];

  int checks;
  int passed;

  stage0_if bus ();

  assign bus.mem_rdata  = mem[bus.mem_addr];
  assign bus.cache_hit  = hit;
  assign bus.stg1_state = stg1;
  assign bus.br_taken   = br;
  assign bus.br_target  = tgt;

  stage0 dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] op;
    logic [7:0] dat;
    logic [7:0] e_ir;
    logic [7:0] e_pc;
    int         e_rd;
    int         e_lat;
  } vec_t;

  vec_t vt [10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string      nm,
    input logic [7:0] act,
    input logic [7:0] exp
  );
    checks++;
    if (act === exp)
      passed++;
    else
      $display("FAIL %s act=%h exp=%h",
        nm, act, exp);
  endtask

  initial begin
    int  rd;
    int  cyc;
    logic ok;
    checks = 0;
    passed = 0;
    for (int i = 0; i < 256; i++)
      mem[i] = 8'hA8;
    vt[0] = '{8'h05, 8'h80, 8'h77,
              8'h00, 8'h06, 1, 2};
    vt[1] = '{8'h10, 8'h31, 8'h99,
              8'h99, 8'h12, 2, 3};
    vt[2] = '{8'h20, 8'h68, 8'h5A,
              8'h5A, 8'h22, 2, 3};
    vt[3] = '{8'h30, 8'hA8, 8'h12,
              8'h00, 8'h31, 1, 2};
    vt[4] = '{8'h50, 8'h70, 8'h34,
              8'h00, 8'h51, 1, 2};
    vt[5] = '{8'h60, 8'hF8, 8'h56,
              8'h00, 8'h61, 1, 2};
    vt[6] = '{8'h70, 8'h98, 8'h9A,
              8'h00, 8'h71, 1, 2};
    vt[7] = '{8'h80, 8'h53, 8'h7E,
              8'h7E, 8'h82, 2, 3};
    vt[8] = '{8'hA0, 8'h28, 8'hE1,
              8'hE1, 8'hA2, 2, 3};
    vt[9] = '{8'hFF, 8'h4C, 8'hC3,
              8'hC3, 8'h01, 2, 3};

    clr  = 1'b1;
    hit  = 1'b1;
    stg1 = 1'b1;
    br   = 1'b0;
    tgt  = 8'h00;
    tick();
    tick();
    chk("rst_pc", bus.pc, 8'h00);
    chk("rst_instr", bus.instr, 8'h00);
    chk("rst_ir", bus.ir_data, 8'h00);
    chk("rst_v", {7'd0, bus.stg0_state}, 8'd0);
    chk("rst_rd", {7'd0, bus.mem_rd}, 8'd0);

    // ADD dir from reset release
    mem[0] = 8'h02;
    mem[1] = 8'h3C;
    clr = 1'b0;
    tick();
    chk("r0_rd", {7'd0, bus.mem_rd}, 8'd1);
    chk("r0_addr", bus.mem_addr, 8'h00);
    tick();
    chk("r1_rd", {7'd0, bus.mem_rd}, 8'd1);
    chk("r1_addr", bus.mem_addr, 8'h01);
    tick();
    chk("full_rd", {7'd0, bus.mem_rd}, 8'd0);
    tick();
    chk("c4_v", {7'd0, bus.stg0_state}, 8'd1);
    chk("c4_instr", bus.instr, 8'h02);
    chk("c4_ir", bus.ir_data, 8'h3C);
    chk("c4_pc", bus.pc, 8'h02);

    // operand read misses for 3 cycles
    mem[8'h90] = 8'h0A;
    mem[8'h91] = 8'h55;
    mem[8'h92] = 8'h88;
    mem[8'h93] = 8'h18;
    mem[8'h94] = 8'h11;
    mem[8'h40] = 8'h90;
    br  = 1'b1;
    tgt = 8'h90;
    tick();
    br = 1'b0;
    tick();
    hit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("miss_rd", {7'd0, bus.mem_rd}, 8'd1);
      chk("miss_addr", bus.mem_addr, 8'h91);
      chk("miss_pc", bus.pc, 8'h91);
    end
    hit = 1'b1;
    tick();
    chk("miss_cap_pc", bus.pc, 8'h92);
    tick();
    chk("miss_instr", bus.instr, 8'h0A);
    chk("miss_ir", bus.ir_data, 8'h55);
    chk("miss_v", {7'd0, bus.stg0_state}, 8'd1);

    // stage 1 busy for 10 cycles
    tick();
    chk("ho_v", {7'd0, bus.stg0_state}, 8'd0);
    stg1 = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.stg0_state !== 1'b0
          || bus.instr !== 8'h0A)
        ok = 1'b0;
    end
    chk("busy_hold", {7'd0, ok}, 8'd1);
    chk("busy_rd", {7'd0, bus.mem_rd}, 8'd0);
    chk("busy_pc", bus.pc, 8'h93);
    stg1 = 1'b1;
    tick();
    chk("busy_v", {7'd0, bus.stg0_state}, 8'd1);
    chk("busy_instr", bus.instr, 8'h88);
    chk("busy_ir", bus.ir_data, 8'h00);

    // branch during an operand miss
    stg1 = 1'b0;
    tick();
    hit = 1'b0;
    tick();
    br  = 1'b1;
    tgt = 8'h40;
    tick();
    br = 1'b0;
    chk("br_rd", {7'd0, bus.mem_rd}, 8'd1);
    chk("br_addr", bus.mem_addr, 8'h40);
    chk("br_instr", bus.instr, 8'h88);
    chk("br_v", {7'd0, bus.stg0_state}, 8'd1);
    hit  = 1'b1;
    stg1 = 1'b1;
    tick();
    tick();
    chk("br_new_instr", bus.instr, 8'h90);
    chk("br_new_ir", bus.ir_data, 8'h00);
    chk("br_new_pc", bus.pc, 8'h41);

    // table of single instructions
    for (int v = 0; v < 10; v++) begin
      mem[vt[v].addr] = vt[v].op;
      mem[8'(vt[v].addr + 8'd1)] = vt[v].dat;
      br  = 1'b1;
      tgt = vt[v].addr;
      tick();
      br  = 1'b0;
      rd  = 0;
      cyc = 0;
      while (bus.stg0_state !== 1'b1
             && cyc < 10) begin
        if (bus.mem_rd === 1'b1 && hit)
          rd++;
        tick();
        cyc++;
      end
      chk("t_instr", bus.instr, vt[v].op);
      chk("t_ir", bus.ir_data, vt[v].e_ir);
      chk("t_pc", bus.pc, vt[v].e_pc);
      chk("t_reads", 8'(rd), 8'(vt[v].e_rd));
      chk("t_lat", 8'(cyc), 8'(vt[v].e_lat));
    end

    // reset asserted mid-wait
    hit = 1'b0;
    br  = 1'b1;
    tgt = 8'h23;
    tick();
    br = 1'b0;
    #2;
    clr = 1'b1;
    #1;
    chk("ar_pc", bus.pc, 8'h00);
    chk("ar_rd", {7'd0, bus.mem_rd}, 8'd0);
    chk("ar_instr", bus.instr, 8'h00);
    chk("ar_ir", bus.ir_data, 8'h00);
    chk("ar_v", {7'd0, bus.stg0_state}, 8'd0);
    hit = 1'b1;
    tick();
    clr = 1'b0;
    chk("rel_rd0", {7'd0, bus.mem_rd}, 8'd0);
    tick();
    chk("rel_rd1", {7'd0, bus.mem_rd}, 8'd1);
    chk("rel_addr", bus.mem_addr, 8'h00);

    $display("%0d/%0d checks passed",
      passed, checks);
    $finish;
  end

endmodule
